// File: rtl/hazard_controller.sv
// Stall/flush sequencer for load-use, taken-branch and multi-cycle MDU hazards.
// Optional perf counters enabled by defining HAZARD_STALL_PERF_EN.
module hazard_controller #(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       IDEX_MemRead_i,
    input  logic       IDEX_mdu_i,
    input  logic [4:0] IDEX_Rt_i,
    input  logic [4:0] IFID_Rs_i,
    input  logic [4:0] IFID_Rt_i,
    input  logic       branch_taken_i,
    output logic       PC_write_o,
    output logic       IFID_write_o,
    output logic       IFID_flush_o,
    output logic       IDEX_write_o,
    output logic       IDEX_flush_o,
    output logic       EXMEM_flush_o,
    output logic       mdu_done_o
`ifdef HAZARD_STALL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [3:0] CntLoad = 4'(MDU_LATENCY - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic mdu_stall;
    logic load_use;
    logic raw_match;

    assign raw_match = (IDEX_Rt_i != 5'd0) &&
                       ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    // The detect cycle in IDLE already counts as the first stall cycle.
    assign mdu_stall = !rst_i &&
                       (((state_q == IDLE) && IDEX_mdu_i) || (state_q == BUSY));

    assign load_use = !rst_i && (state_q == IDLE) && !IDEX_mdu_i &&
                      IDEX_MemRead_i && raw_match;

    assign PC_write_o    = !(mdu_stall || load_use);
    assign IFID_write_o  = !(mdu_stall || load_use);
    assign IDEX_write_o  = !mdu_stall;
    assign IDEX_flush_o  = load_use;
    assign EXMEM_flush_o = mdu_stall;
    assign IFID_flush_o  = !rst_i && branch_taken_i && !mdu_stall && !load_use;
    assign mdu_done_o    = !rst_i && (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (IDEX_mdu_i) begin
                    state_d = BUSY;
                    cnt_d   = CntLoad;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!PC_write_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (IFID_flush_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline stall/flush sequencer for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use dependences, handled with a one-cycle bubble;
- taken branches resolved in ID, handled by flushing IF/ID;
- multi-cycle MUL/DIV in EX, which freezes the front end for a fixed latency.

It drives the write enables and flushes of PC, IF/ID, ID/EX and EX/MEM.

## Interface
Parameters:
- MDU_LATENCY, 4, stall cycles per MUL/DIV op (legal 2..16)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_mdu_i  in  1  instruction in EX is MULT/MULTU/DIV/DIVU
- IDEX_Rt_i  in  5  load destination register in EX
- IFID_Rs_i  in  5  source register Rs of the instruction in ID
- IFID_Rt_i  in  5  source register Rt of the instruction in ID
- branch_taken_i  in  1  branch/jump resolved taken in ID
- PC_write_o  out  1  PC update enable
- IFID_write_o  out  1  IF/ID load enable
- IFID_flush_o  out  1  clear IF/ID to NOP
- IDEX_write_o  out  1  ID/EX load enable
- IDEX_flush_o  out  1  load a bubble into ID/EX (all control bits 0)
- EXMEM_flush_o  out  1  load a bubble into EX/MEM
- mdu_done_o  out  1  MDU result valid this cycle

## Operation
**Clock and reset**
- Single clock domain: clk_i.
- Reset is synchronous and active-high on rst_i.

**Load-use hazard**
- Condition: IDEX_MemRead_i=1, IDEX_Rt_i≠0, and IDEX_Rt_i equals IFID_Rs_i or IFID_Rt_i.
- Response (combinational): PC_write_o=0, IFID_write_o=0, IDEX_flush_o=1.
- Re-detection cannot occur on the next cycle, because ID/EX then holds the bubble.

**Branch**
- When branch_taken_i=1 and no stall is active: IFID_flush_o=1.
- All enables stay 1.

**MDU state machine** (states IDLE, BUSY, DONE; counter cnt of 4 bits)
- IDLE:
  - If IDEX_mdu_i=1: assert the stall set, load cnt=MDU_LATENCY-2, go to BUSY.
  - Stall set: PC_write_o=0, IFID_write_o=0, IDEX_write_o=0, EXMEM_flush_o=1.
- BUSY:
  - Assert the stall set.
  - If cnt=0, go to DONE; otherwise cnt decrements by 1.
- DONE:
  - mdu_done_o=1; all enables 1; EXMEM_flush_o=0, so the MDU result enters EX/MEM.
  - IDEX_mdu_i is ignored in this cycle.
  - Unconditionally go to IDLE.

**Priority**
- MDU stall (IDLE-detect or BUSY) > load-use > branch flush.
- A suppressed branch is re-evaluated when ID is released; the controller keeps no memory of it.
- IDEX_mdu_i and IDEX_MemRead_i both 1 is treated as an MDU op; load-use is suppressed.

**Default outputs**
- All write enables 1; all flushes 0; mdu_done_o=0.

## Timing
**Reset**
- While rst_i=1: state→IDLE, cnt→0.
- Outputs are forced to defaults: enables 1, flushes 0, mdu_done_o=0.
- A reset asserted mid-BUSY aborts the op; no mdu_done_o pulse is produced.

**Latency**
- All outputs are a combinational function of the current state and inputs, i.e. zero-cycle response to hazard inputs.

**MDU op**
- Stall set asserted for exactly MDU_LATENCY consecutive cycles, starting with the cycle IDEX_mdu_i is first seen in IDLE.
- mdu_done_o is asserted on the following cycle.
- EX occupancy is MDU_LATENCY+1 cycles in total.

**Back-to-back MDU ops**
- The second op enters EX on the cycle after DONE, and is detected there in IDLE.
- There is no idle gap beyond the DONE cycle.

**Load-use**
- Exactly one bubble cycle per hazard.

## Configuration
**HAZARD_STALL_PERF_EN**
- Defined: adds ports stall_cnt_o (out, 32) and flush_cnt_o (out, 32).
- stall_cnt_o increments every cycle PC_write_o=0.
- flush_cnt_o increments every cycle IFID_flush_o=1.
- Both counters saturate at 0xFFFFFFFF, clear to 0 on rst_i, and are not incremented during the reset cycle itself.
- Undefined: both ports and both counters are absent; behaviour is otherwise identical.

## Test plan
- **Load-use:** IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 → one cycle with PC_write_o=0, IFID_write_o=0, IDEX_flush_o=1. Repeat with IDEX_Rt_i=0 → no stall.
- **Branch:** branch_taken_i=1 with no hazard → IFID_flush_o=1 for 1 cycle; all enables stay 1.
- **MDU, MDU_LATENCY=4:** IDEX_mdu_i held 1 → stall set for 4 cycles, then mdu_done_o=1 for 1 cycle, then IDLE. With IDEX_mdu_i still 1 in the next cycle, a second 4-cycle stall follows immediately.
- **Priority:** during BUSY, drive a load-use condition plus branch_taken_i=1 → IFID_flush_o=0 and IDEX_flush_o=0. Same load-use plus branch in IDLE with IDEX_mdu_i=0 → IDEX_flush_o=1, IFID_flush_o=0.
- **Reset mid-op:** rst_i=1 on the 2nd BUSY cycle → next cycle IDLE, enables 1, and no mdu_done_o pulse ever.
- **HAZARD_STALL_PERF_EN:** one MDU op (latency 4), then one load-use, then one branch → stall_cnt_o=5, flush_cnt_o=1.
